// File: rtl/audio_note_sequencer.sv
// Note sequencer: queues 32-bit note words and plays each one as a tone
// followed by a silent gap, feeding the audio controller buzzer datapath.
module audio_note_sequencer #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_TICKS  = 10
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [31:0]                       Note_Data,
    input  logic                              Note_Valid,
    output logic                              Note_Ready,
    input  logic                              Run,
    input  logic                              Abort,
    output logic [31:0]                       Audio_Display,
    output logic                              Audio_Enable,
    output logic                              Busy,
    output logic                              Done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Fifo_Count
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam longint unsigned PLAYMAX = 64'd65535 * 64'(TICK_DIV);
    localparam longint unsigned GAPCYC  = 64'(GAP_TICKS) * 64'(TICK_DIV);
    localparam longint unsigned TOPC = (PLAYMAX > GAPCYC) ? PLAYMAX : GAPCYC;
    localparam int CW = $clog2(TOPC + 1);
    localparam logic [CW-1:0] GAP_LAST = (GAPCYC == 0) ? '0 : CW'(GAPCYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [15:0]     tone_q, tone_d;
    logic [31:0]     disp_q, disp_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rdy_q, rdy_d;
    logic            full, push, pop;
    logic [31:0]     head;
    logic [CW-1:0]   play_last;

    assign full      = (cnt_q == NW'(FIFO_DEPTH));
    assign push      = Note_Valid & ~full & ~Abort;
    assign pop       = (state_q == LOAD) & ~Abort;
    assign head      = mem_q[rd_q];
    assign play_last = CW'(head[31:16]) * CW'(TICK_DIV) - CW'(1);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tone_d  = tone_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + NW'(push) - NW'(pop);
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Run && cnt_q != '0) state_d = LOAD;
            end
            LOAD: begin
                tone_d = head[15:0];
                if (head[31:16] == 16'd0) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    state_d = PLAY;
                    cyc_d   = play_last;
                end
            end
            PLAY: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - CW'(1);
                end else if (GAP_TICKS != 0) begin
                    state_d = GAP;
                    cyc_d   = GAP_LAST;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cyc_q != '0) cyc_d = cyc_q - CW'(1);
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE && state_q != IDLE && cnt_d == '0) done_d = 1'b1;
        // Abort overrides everything, including a push in the same cycle
        if (Abort) begin
            state_d = IDLE;
            cyc_d   = '0;
            tone_d  = '0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
        disp_d = (state_d == PLAY) ? {16'b0, tone_d} : 32'd0;
        en_d   = (state_d == PLAY) && (tone_d != 16'd0);
        busy_d = (state_d != IDLE);
        rdy_d  = (cnt_d != NW'(FIFO_DEPTH));
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_q] <= Note_Data;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            tone_q  <= '0;
            disp_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            tone_q  <= tone_d;
            disp_q  <= disp_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign Audio_Display = disp_q;
    assign Audio_Enable  = en_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Note_Ready    = rdy_q;
    assign Fifo_Count    = cnt_q;

endmodule
